cache_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single lookup port of the set-associative cache between `NUM_REQ` requesters (trace readers, prefetcher, CPU-model ports). It accepts one read/write request at a time, drives it into the cache lookup, and waits for the hit/miss verdict. It then returns that verdict to the owning requester and keeps saturating hit/miss statistics. Only one transaction is outstanding at any time.

---
 rtl/cache_req_arbiter.sv | 128 ++++++++++++
 tb/tb_cache_req_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter that shares one cache lookup port among NUM_REQ requesters.
// One transaction in flight at a time; verdicts are routed back and counted.
module cache_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 24,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cache_req_valid,
    output logic                      cache_req_write,
    output logic [ADDR_W-1:0]         cache_req_addr,
    input  logic                      cache_req_ready,
    input  logic                      cache_resp_valid,
    input  logic                      cache_resp_hit,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic                      resp_hit,
    input  logic                      stat_clr,
    output logic [CNT_W-1:0]          hit_count,
    output logic [CNT_W-1:0]          miss_count,
    output logic                      busy,
    output logic                      protocol_err
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    logic               hit_inc;
    logic               miss_inc;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin : grant_sel
        logic [PTR_W:0] idx_w;
        idx_w     = '0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_w = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (idx_w >= (PTR_W+1)'(NUM_REQ)) begin
                idx_w = idx_w - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_any && req_valid[idx_w[PTR_W-1:0]]) begin
                grant_any                  = 1'b1;
                grant[idx_w[PTR_W-1:0]]    = 1'b1;
                grant_idx                  = idx_w[PTR_W-1:0];
            end
        end
    end

    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign busy      = (state != IDLE);
    assign next_ptr  = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
    assign hit_inc   = (state == WAIT) && cache_resp_valid && cache_resp_hit;
    assign miss_inc  = (state == WAIT) && cache_resp_valid && !cache_resp_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            owner           <= '0;
            cache_req_valid <= 1'b0;
            cache_req_write <= 1'b0;
            cache_req_addr  <= '0;
            resp_valid      <= '0;
            resp_hit        <= 1'b0;
            protocol_err    <= 1'b0;
            hit_count       <= '0;
            miss_count      <= '0;
        end else begin
            resp_valid <= '0;
            if (cache_resp_valid && state != WAIT) begin
                protocol_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner           <= grant_idx;
                        cache_req_write <= req_write[grant_idx];
                        cache_req_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                        cache_req_valid <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cache_req_ready) begin
                        cache_req_valid <= 1'b0;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (cache_resp_valid) begin
                        resp_valid[owner] <= 1'b1;
                        resp_hit          <= cache_resp_hit;
                        rr_ptr            <= next_ptr;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Clear takes priority over a coincident increment.
            if (stat_clr) begin
                hit_count  <= '0;
                miss_count <= '0;
            end else begin
                if (hit_inc && hit_count != {CNT_W{1'b1}}) begin
                    hit_count <= hit_count + CNT_W'(1);
                end
                if (miss_inc && miss_count != {CNT_W{1'b1}}) begin
                    miss_count <= miss_count + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_cache_req_arbiter.sv
`timescale 1ns/1ps
module tb_cache_req_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 24;
    localparam int CNT_W   = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      cache_req_valid;
    logic                      cache_req_write;
    logic [ADDR_W-1:0]         cache_req_addr;
    logic                      cache_req_ready;
    logic                      cache_resp_valid;
    logic                      cache_resp_hit;
    logic [NUM_REQ-1:0]        resp_valid;
    logic                      resp_hit;
    logic                      stat_clr;
    logic [CNT_W-1:0]          hit_count;
    logic [CNT_W-1:0]          miss_count;
    logic                      busy;
    logic                      protocol_err;

    int checks = 0;
    int errors = 0;

    cache_req_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_ready(req_ready),
        .cache_req_valid(cache_req_valid), .cache_req_write(cache_req_write),
        .cache_req_addr(cache_req_addr), .cache_req_ready(cache_req_ready),
        .cache_resp_valid(cache_resp_valid), .cache_resp_hit(cache_resp_hit),
        .resp_valid(resp_valid), .resp_hit(resp_hit),
        .stat_clr(stat_clr), .hit_count(hit_count), .miss_count(miss_count),
        .busy(busy), .protocol_err(protocol_err)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic hit;
        int   owner;
        int   hits;
        int   misses;
    } fair_vec_t;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] ready;
    } grant_vec_t;

    fair_vec_t  fv[8];
    grant_vec_t gv[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_addr(input int i);
        return 24'h100000 + 24'(i * 16);
    endfunction

    // Single-requester transaction, entered and left at a falling edge in IDLE.
    task automatic txn(input int who, input logic hit, input logic clr);
        req_valid = 4'(1 << who);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("txn_cache_req_valid", 32'(cache_req_valid), 32'd1);
        chk("txn_cache_req_addr", 32'(cache_req_addr), 32'(exp_addr(who)));
        @(posedge clk); #1;
        cache_resp_valid = 1'b1;
        cache_resp_hit   = hit;
        stat_clr         = clr;
        @(posedge clk); #1;
        cache_resp_valid = 1'b0;
        stat_clr         = 1'b0;
        @(negedge clk);
        chk("txn_resp_valid", 32'(resp_valid), 32'(1 << who));
        chk("txn_resp_hit", 32'(resp_hit), 32'(hit));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_hits;

        fv[0] = '{1'b1, 0, 1, 0};
        fv[1] = '{1'b0, 1, 1, 1};
        fv[2] = '{1'b1, 2, 2, 1};
        fv[3] = '{1'b0, 3, 2, 2};
        fv[4] = '{1'b1, 0, 3, 2};
        fv[5] = '{1'b0, 1, 3, 3};
        fv[6] = '{1'b1, 2, 4, 3};
        fv[7] = '{1'b0, 3, 4, 4};

        // Expected grants with rr_ptr = 3.
        gv[0] = '{4'b1111, 4'b1000};
        gv[1] = '{4'b0111, 4'b0001};
        gv[2] = '{4'b0110, 4'b0010};
        gv[3] = '{4'b0100, 4'b0100};
        gv[4] = '{4'b0000, 4'b0000};
        gv[5] = '{4'b1001, 4'b1000};

        rst              = 1'b1;
        req_valid        = 4'hF;
        req_write        = 4'b1010;
        cache_req_ready  = 1'b1;
        cache_resp_valid = 1'b0;
        cache_resp_hit   = 1'b0;
        stat_clr         = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = exp_addr(i);

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_cache_req_valid", 32'(cache_req_valid), 32'd0);
        chk("rst_cache_req_write", 32'(cache_req_write), 32'd0);
        chk("rst_cache_req_addr", 32'(cache_req_addr), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_hit", 32'(resp_hit), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_protocol_err", 32'(protocol_err), 32'd0);
        chk("rst_hit_count", 32'(hit_count), 32'd0);
        chk("rst_miss_count", 32'(miss_count), 32'd0);
        rst = 1'b0;
        #1;

        // Round-robin with all requesters continuously valid.
        for (int t = 0; t < 8; t++) begin
            chk("rr_req_ready", 32'(req_ready), 32'(1 << fv[t].owner));
            @(posedge clk); #1;
            @(negedge clk);
            chk("rr_cache_req_valid", 32'(cache_req_valid), 32'd1);
            chk("rr_cache_req_addr", 32'(cache_req_addr), 32'(exp_addr(fv[t].owner)));
            chk("rr_cache_req_write", 32'(cache_req_write), 32'(fv[t].owner % 2));
            chk("rr_busy", 32'(busy), 32'd1);
            chk("rr_ready_blocked", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            cache_resp_valid = 1'b1;
            cache_resp_hit   = fv[t].hit;
            @(posedge clk); #1;
            cache_resp_valid = 1'b0;
            @(negedge clk);
            chk("rr_resp_valid", 32'(resp_valid), 32'(1 << fv[t].owner));
            chk("rr_resp_hit", 32'(resp_hit), 32'(fv[t].hit));
            chk("rr_hit_count", 32'(hit_count), 32'(fv[t].hits));
            chk("rr_miss_count", 32'(miss_count), 32'(fv[t].misses));
        end

        // Back-pressure: lookup held for 5 cycles with cache_req_ready low.
        req_valid = 4'b0100;
        req_addr[2*ADDR_W +: ADDR_W] = 24'hABCDE8;
        req_write[2] = 1'b1;
        cache_req_ready = 1'b0;
        #1;
        chk("bp_req_ready", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        req_valid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_cache_req_valid", 32'(cache_req_valid), 32'd1);
            chk("bp_cache_req_addr", 32'(cache_req_addr), 32'hABCDE8);
            chk("bp_cache_req_write", 32'(cache_req_write), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        cache_req_ready = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        cache_resp_valid = 1'b1;
        cache_resp_hit   = 1'b0;
        @(posedge clk); #1;
        cache_resp_valid = 1'b0;
        @(negedge clk);
        chk("bp_resp_valid", 32'(resp_valid), 32'b0100);
        chk("bp_resp_hit", 32'(resp_hit), 32'd0);
        chk("bp_miss_count", 32'(miss_count), 32'd5);
        chk("bp_hit_count", 32'(hit_count), 32'd4);
        req_addr[2*ADDR_W +: ADDR_W] = exp_addr(2);
        req_write[2] = 1'b0;

        // Grant recomputed every IDLE cycle as requesters come and go.
        for (int g = 0; g < 6; g++) begin
            req_valid = gv[g].valid;
            #1;
            chk("grant_table", 32'(req_ready), 32'(gv[g].ready));
        end
        req_valid = '0;

        // Clear, then saturate the hit counter.
        @(negedge clk);
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        @(negedge clk);
        chk("clr_hit_count", 32'(hit_count), 32'd0);
        chk("clr_miss_count", 32'(miss_count), 32'd0);
        for (int k = 0; k < 17; k++) begin
            txn(k % 4, 1'b1, 1'b0);
            exp_hits = (k + 1 > 15) ? 15 : k + 1;
            chk("sat_hit_count", 32'(hit_count), 32'(exp_hits));
        end
        txn(0, 1'b1, 1'b1);
        chk("clr_race_hit_count", 32'(hit_count), 32'd0);
        txn(1, 1'b0, 1'b0);
        chk("miss_after_clr", 32'(miss_count), 32'd1);

        // Stray verdict in IDLE.
        chk("err_before", 32'(protocol_err), 32'd0);
        cache_resp_valid = 1'b1;
        cache_resp_hit   = 1'b1;
        @(posedge clk); #1;
        cache_resp_valid = 1'b0;
        @(negedge clk);
        chk("err_set", 32'(protocol_err), 32'd1);
        chk("err_hit_count", 32'(hit_count), 32'd0);
        chk("err_miss_count", 32'(miss_count), 32'd1);
        chk("err_resp_valid", 32'(resp_valid), 32'd0);

        // Reset while waiting for a verdict.
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_cache_req_valid", 32'(cache_req_valid), 32'd0);
        rst = 1'b1;
        cache_resp_valid = 1'b1;
        cache_resp_hit   = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cache_resp_valid = 1'b0;
        @(negedge clk);
        chk("mrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_protocol_err", 32'(protocol_err), 32'd0);
        chk("mrst_hit_count", 32'(hit_count), 32'd0);
        @(negedge clk);
        chk("mrst_resp_valid_late", 32'(resp_valid), 32'd0);
        req_valid = 4'hF;
        #1;
        chk("mrst_req_ready", 32'(req_ready), 32'b0001);
        req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
